// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared types and constants for the flash arbiter.
//   state_e : arbiter FSM states
//   port_e  : requester identity (A = instruction fetch, B = data)
//   WORD_W  : address/data width
package flash_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/flash_arb_cache.sv
// flash_arb_cache: single-entry read cache (tag, data, valid) with hit compare.
// Only instantiated when FLASH_ARB_CACHE_EN is defined.
// Ports:
//   clk, reset      : clock, async active-low reset (clears valid)
//   fill_en         : load the entry with fill_address/fill_value
//   lookup_address  : address compared against the stored tag
//   hit, hit_value  : entry valid and tag match; stored data
module flash_arb_cache
  import flash_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_en,
  input  logic [WORD_W-1:0] fill_address,
  input  logic [WORD_W-1:0] fill_value,
  input  logic [WORD_W-1:0] lookup_address,
  output logic              hit,
  output logic [WORD_W-1:0] hit_value
);

  logic [WORD_W-1:0] tag_q;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fill_en) begin
      tag_q   <= fill_address;
      data_q  <= fill_value;
      valid_q <= 1'b1;
    end
  end

  assign hit       = valid_q && (lookup_address == tag_q);
  assign hit_value = data_q;

endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares the single-port SPI flash controller between the
// instruction-fetch port (A) and the data port (B). Reads are serialised with
// round-robin tie-breaking; writes complete locally since flash is read-only.
// Optional macro FLASH_ARB_CACHE_EN adds a one-entry read cache.
// Ports:
//   clk, reset                : clock, async active-low reset
//   {a,b}_address/sel/read/write_mask/write_value_in : requester inputs
//   {a,b}_read_value_out, {a,b}_ready_out            : requester response
//   flash_address/sel/read/write_mask/write_value_out: flash request
//   flash_read_value_in, flash_ready_in              : flash response
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// BUSY  | flash read in flight, address held stable
// RESP  | one-cycle ready pulse to the granted port
module flash_arbiter
  import flash_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] a_address_in,
  input  logic              a_sel_in,
  input  logic              a_read_in,
  input  logic [3:0]        a_write_mask_in,
  input  logic [WORD_W-1:0] a_write_value_in,
  output logic [WORD_W-1:0] a_read_value_out,
  output logic              a_ready_out,
  input  logic [WORD_W-1:0] b_address_in,
  input  logic              b_sel_in,
  input  logic              b_read_in,
  input  logic [3:0]        b_write_mask_in,
  input  logic [WORD_W-1:0] b_write_value_in,
  output logic [WORD_W-1:0] b_read_value_out,
  output logic              b_ready_out,
  output logic [WORD_W-1:0] flash_address_out,
  output logic              flash_sel_out,
  output logic              flash_read_out,
  output logic [3:0]        flash_write_mask_out,
  output logic [WORD_W-1:0] flash_write_value_out,
  input  logic [WORD_W-1:0] flash_read_value_in,
  input  logic              flash_ready_in
);

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  port_e             last_grant_q, last_grant_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;

  logic              a_req, b_req;
  port_e             pick;
  logic              pick_read;
  logic [WORD_W-1:0] pick_addr;
  logic              cache_hit;
  logic [WORD_W-1:0] cache_value;

  // Write data is meaningless to a read-only flash.
  logic unused_write_value;
  assign unused_write_value = ^{a_write_value_in, b_write_value_in};

  assign a_req = a_sel_in && (a_read_in || (|a_write_mask_in));
  assign b_req = b_sel_in && (b_read_in || (|b_write_mask_in));

  always_comb begin
    pick = PORT_A;
    if (a_req && b_req) begin
      pick = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      pick = PORT_B;
    end
  end

  // A request with the read strobe set is a read even if write bits are set.
  assign pick_read = (pick == PORT_A) ? a_read_in    : b_read_in;
  assign pick_addr = (pick == PORT_A) ? a_address_in : b_address_in;

`ifdef FLASH_ARB_CACHE_EN
  logic cache_fill;
  assign cache_fill = (state_q == BUSY) && flash_ready_in;

  flash_arb_cache u_cache (
    .clk            (clk),
    .reset          (reset),
    .fill_en        (cache_fill),
    .fill_address   (addr_q),
    .fill_value     (flash_read_value_in),
    .lookup_address (pick_addr),
    .hit            (cache_hit),
    .hit_value      (cache_value)
  );
`else
  assign cache_hit   = 1'b0;
  assign cache_value = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= PORT_A;
      last_grant_q <= PORT_B;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_d      = pick;
          last_grant_d = pick;
          if (pick_read && cache_hit) begin
            data_d  = cache_value;
            state_d = RESP;
          end else if (pick_read) begin
            addr_d  = pick_addr;
            state_d = BUSY;
          end else begin
            data_d  = '0;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (flash_ready_in) begin
          data_d  = flash_read_value_in;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Responses decode registered state only; sel masks a port that walked away.
  assign a_ready_out      = a_sel_in && (state_q == RESP) && (grant_q == PORT_A);
  assign b_ready_out      = b_sel_in && (state_q == RESP) && (grant_q == PORT_B);
  assign a_read_value_out = a_ready_out ? data_q : '0;
  assign b_read_value_out = b_ready_out ? data_q : '0;

  assign flash_sel_out         = (state_q == BUSY);
  assign flash_read_out        = (state_q == BUSY);
  assign flash_address_out     = addr_q;
  assign flash_write_mask_out  = '0;
  assign flash_write_value_out = '0;

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed bench for flash_arbiter with a behavioural flash
// that answers 10 cycles after sel rises.
module tb_flash_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] a_address_in, b_address_in;
  logic        a_sel_in, b_sel_in, a_read_in, b_read_in;
  logic [3:0]  a_write_mask_in, b_write_mask_in;
  logic [31:0] a_write_value_in, b_write_value_in;
  logic [31:0] a_read_value_out, b_read_value_out;
  logic        a_ready_out, b_ready_out;
  logic [31:0] flash_address_out;
  logic        flash_sel_out, flash_read_out;
  logic [3:0]  flash_write_mask_out;
  logic [31:0] flash_write_value_out;
  logic [31:0] flash_read_value_in;
  logic        flash_ready_in;

  int n_checks = 0;
  int n_pass   = 0;
  int sel_count = 0;
  int sel_snap;
  logic [3:0] fcnt;

  flash_arbiter dut (
    .clk                   (clk),
    .reset                 (reset),
    .a_address_in          (a_address_in),
    .a_sel_in              (a_sel_in),
    .a_read_in             (a_read_in),
    .a_write_mask_in       (a_write_mask_in),
    .a_write_value_in      (a_write_value_in),
    .a_read_value_out      (a_read_value_out),
    .a_ready_out           (a_ready_out),
    .b_address_in          (b_address_in),
    .b_sel_in              (b_sel_in),
    .b_read_in             (b_read_in),
    .b_write_mask_in       (b_write_mask_in),
    .b_write_value_in      (b_write_value_in),
    .b_read_value_out      (b_read_value_out),
    .b_ready_out           (b_ready_out),
    .flash_address_out     (flash_address_out),
    .flash_sel_out         (flash_sel_out),
    .flash_read_out        (flash_read_out),
    .flash_write_mask_out  (flash_write_mask_out),
    .flash_write_value_out (flash_write_value_out),
    .flash_read_value_in   (flash_read_value_in),
    .flash_ready_in        (flash_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_data(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEAD_BEEF : {addr[15:0], 16'hA5A5};
  endfunction

  // Flash model: ready is visible exactly 10 cycles after sel first appears.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt           <= '0;
      flash_ready_in <= 1'b0;
    end else begin
      flash_ready_in <= 1'b0;
      if (flash_sel_out && !flash_ready_in) begin
        if (fcnt == 4'd9) begin
          flash_ready_in <= 1'b1;
          fcnt           <= '0;
        end else begin
          fcnt <= fcnt + 4'd1;
        end
      end
    end
  end
  assign flash_read_value_in = flash_ready_in ? model_data(flash_address_out) : 32'h0;

  always @(posedge clk) if (flash_sel_out) sel_count <= sel_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_drive(input logic sel, input logic rd, input logic [31:0] addr);
    a_sel_in = sel; a_read_in = rd; a_address_in = addr;
  endtask

  task automatic b_drive(input logic sel, input logic rd, input logic [3:0] mask,
                         input logic [31:0] addr);
    b_sel_in = sel; b_read_in = rd; b_write_mask_in = mask; b_address_in = addr;
  endtask

  initial begin
    reset = 1'b0;
    a_drive(1'b0, 1'b0, 32'h0);
    b_drive(1'b0, 1'b0, 4'h0, 32'h0);
    a_write_mask_in  = 4'h0;
    a_write_value_in = 32'h0;
    b_write_value_in = 32'h1234_5678;
    tick(3);

    // Reset state
    chk("rst_flash_sel", {31'b0, flash_sel_out}, 32'h0);
    chk("rst_flash_read", {31'b0, flash_read_out}, 32'h0);
    chk("rst_flash_addr", flash_address_out, 32'h0);
    chk("rst_wmask", {28'b0, flash_write_mask_out}, 32'h0);
    chk("rst_wvalue", flash_write_value_out, 32'h0);

    // Simultaneous requests at reset exit: A first (last_grant resets to B)
    a_drive(1'b1, 1'b1, 32'h100);
    b_drive(1'b1, 1'b1, 4'h0, 32'h300);
    #1;
    chk("rst_a_ready", {31'b0, a_ready_out}, 32'h0);
    chk("rst_b_ready", {31'b0, b_ready_out}, 32'h0);
    chk("rst_a_value", a_read_value_out, 32'h0);
    @(negedge clk) reset = 1'b1;
    tick(1);                                   // N+1
    chk("p1_sel_a", {31'b0, flash_sel_out}, 32'h1);
    chk("p1_addr_a", flash_address_out, 32'h100);
    tick(10);                                  // N+11 = M
    chk("p1_no_comb_ready", {31'b0, a_ready_out}, 32'h0);
    tick(1);                                   // M+1
    chk("p1_a_ready", {31'b0, a_ready_out}, 32'h1);
    chk("p1_a_value", a_read_value_out, 32'hDEAD_BEEF);
    chk("p1_sel_low", {31'b0, flash_sel_out}, 32'h0);
    chk("p1_b_ready", {31'b0, b_ready_out}, 32'h0);
    chk("p1_b_value", b_read_value_out, 32'h0);
    a_drive(1'b0, 1'b0, 32'h0);
    tick(1);                                   // M+2 IDLE, B granted
    chk("p1_a_ready_off", {31'b0, a_ready_out}, 32'h0);
    chk("p1_gap_sel", {31'b0, flash_sel_out}, 32'h0);
    tick(1);                                   // M+3
    chk("p1_sel_b", {31'b0, flash_sel_out}, 32'h1);
    chk("p1_addr_b", flash_address_out, 32'h300);
    tick(11);
    chk("p1_b_ready", {31'b0, b_ready_out}, 32'h1);
    chk("p1_b_data", b_read_value_out, 32'h0300_A5A5);
    chk("p1_a_quiet", {31'b0, a_ready_out}, 32'h0);
    b_drive(1'b0, 1'b0, 4'h0, 32'h0);
    tick(1);

    // B write: ready next cycle with zero data, flash untouched
    sel_snap = sel_count;
    b_drive(1'b1, 1'b0, 4'hF, 32'h200);
    tick(1);
    chk("wr_b_ready", {31'b0, b_ready_out}, 32'h1);
    chk("wr_b_value", b_read_value_out, 32'h0);
    chk("wr_sel", {31'b0, flash_sel_out}, 32'h0);
    b_drive(1'b0, 1'b0, 4'h0, 32'h0);
    tick(1);
    chk("wr_b_ready_off", {31'b0, b_ready_out}, 32'h0);
    tick(1);
    chk("wr_no_flash", sel_count, sel_snap);

    // A drops sel 3 cycles into BUSY: access completes, pulse masked
    a_drive(1'b1, 1'b1, 32'h104);
    tick(1);                                   // T+1
    chk("pv_sel", {31'b0, flash_sel_out}, 32'h1);
    tick(2);                                   // T+3
    a_drive(1'b0, 1'b0, 32'h0);
    tick(8);                                   // T+11 = M
    chk("pv_sel_held", {31'b0, flash_sel_out}, 32'h1);
    chk("pv_addr_held", flash_address_out, 32'h104);
    tick(1);                                   // M+1 RESP
    chk("pv_no_ready", {31'b0, a_ready_out}, 32'h0);
    chk("pv_no_value", a_read_value_out, 32'h0);
    chk("pv_sel_low", {31'b0, flash_sel_out}, 32'h0);
    tick(1);                                   // M+2: must be IDLE again

    // Second tie with last_grant = A: B then A
    a_drive(1'b1, 1'b1, 32'h108);
    b_drive(1'b1, 1'b1, 4'h0, 32'h308);
    tick(1);
    chk("p2_sel_b", {31'b0, flash_sel_out}, 32'h1);
    chk("p2_addr_b", flash_address_out, 32'h308);
    tick(11);
    chk("p2_b_ready", {31'b0, b_ready_out}, 32'h1);
    chk("p2_b_data", b_read_value_out, 32'h0308_A5A5);
    chk("p2_a_quiet", {31'b0, a_ready_out}, 32'h0);
    b_drive(1'b0, 1'b0, 4'h0, 32'h0);
    tick(2);
    chk("p2_sel_a", {31'b0, flash_sel_out}, 32'h1);
    chk("p2_addr_a", flash_address_out, 32'h108);
    tick(2);

    // Reset mid-BUSY: outputs clear immediately
    reset = 1'b0;
    #1;
    chk("mr_sel", {31'b0, flash_sel_out}, 32'h0);
    chk("mr_read", {31'b0, flash_read_out}, 32'h0);
    chk("mr_addr", flash_address_out, 32'h0);
    chk("mr_a_ready", {31'b0, a_ready_out}, 32'h0);
    chk("mr_a_value", a_read_value_out, 32'h0);
    a_drive(1'b0, 1'b0, 32'h0);
    tick(2);
    @(negedge clk) reset = 1'b1;
    tick(1);
    a_drive(1'b1, 1'b1, 32'h100);
    tick(1);
    chk("ar_sel", {31'b0, flash_sel_out}, 32'h1);
    chk("ar_addr", flash_address_out, 32'h100);
    tick(11);
    chk("ar_a_ready", {31'b0, a_ready_out}, 32'h1);
    chk("ar_a_value", a_read_value_out, 32'hDEAD_BEEF);
    a_drive(1'b0, 1'b0, 32'h0);
    tick(1);

`ifdef FLASH_ARB_CACHE_EN
    a_drive(1'b1, 1'b1, 32'h40);
    tick(1);
    chk("c_fill_sel", {31'b0, flash_sel_out}, 32'h1);
    tick(11);
    chk("c_fill_ready", {31'b0, a_ready_out}, 32'h1);
    chk("c_fill_value", a_read_value_out, 32'h0040_A5A5);
    a_drive(1'b0, 1'b0, 32'h0);
    tick(1);
    sel_snap = sel_count;
    a_drive(1'b1, 1'b1, 32'h40);
    tick(1);
    chk("c_hit_ready", {31'b0, a_ready_out}, 32'h1);
    chk("c_hit_value", a_read_value_out, 32'h0040_A5A5);
    chk("c_hit_sel", {31'b0, flash_sel_out}, 32'h0);
    a_drive(1'b0, 1'b0, 32'h0);
    tick(1);
    chk("c_hit_no_flash", sel_count, sel_snap);
    a_drive(1'b1, 1'b1, 32'h44);
    tick(1);
    chk("c_miss_sel", {31'b0, flash_sel_out}, 32'h1);
    chk("c_miss_addr", flash_address_out, 32'h44);
    tick(11);
    chk("c_miss_value", a_read_value_out, 32'h0044_A5A5);
    a_drive(1'b0, 1'b0, 32'h0);
    tick(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
